// File: rtl/count_rank_sorter_pkg.sv
// Shared constants and types for the count-ranking sorter.
package count_rank_sorter_pkg;

    localparam int NUM_IMG = 8;          // list depth (images per batch)
    localparam int CNT_W   = 15;         // match count width
    localparam int ID_W    = 3;          // image id width
    localparam int PTR_W   = ID_W + 1;   // holds 0..NUM_IMG

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        READ    = 1'b1
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] count;
    } rank_entry_t;

endpackage

// File: rtl/count_rank_sorter_if.sv
// Capture/readout bus between the pixel-counter side and the ranking sorter.
interface count_rank_sorter_if;
    import count_rank_sorter_pkg::*;

    logic             busy;
    logic [CNT_W-1:0] count;
    logic             rd_start;
    logic             out_valid;
    logic [ID_W-1:0]  out_id;
    logic [CNT_W-1:0] out_count;
    logic             done;
    logic [PTR_W-1:0] entries;
    logic             full;
    logic             dropped;

    modport master (
        output busy, count, rd_start,
        input  out_valid, out_id, out_count, done, entries, full, dropped
    );

    modport slave (
        input  busy, count, rd_start,
        output out_valid, out_id, out_count, done, entries, full, dropped
    );
endinterface

// File: rtl/count_rank_sorter_rank_slot.sv
// One cell of the sorted list: keeps its entry, takes the new entry, or
// takes the entry of the cell above when the insertion point is higher up.
module count_rank_sorter_rank_slot
    import count_rank_sorter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        ins_en_i,
    input  rank_entry_t new_entry_i,
    input  logic        up_take_i,
    input  rank_entry_t up_entry_i,
    input  logic        up_valid_i,
    output logic        take_o,
    output rank_entry_t entry_o,
    output rank_entry_t next_o,
    output logic        valid_o
);

    rank_entry_t entry_q, entry_d;
    logic        valid_q, valid_d;

    // New entry belongs at or above this cell: cell empty or strictly smaller (ties keep older entry first).
    always_comb begin
        take_o = (!valid_q) || (new_entry_i.count > entry_q.count);
    end

    // Select keep / take-new / shift-down-from-upper for the next cell content.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (clr_i) begin
            entry_d = '0;
            valid_d = 1'b0;
        end else if (ins_en_i && take_o) begin
            if (up_take_i) begin
                entry_d = up_entry_i;
                valid_d = up_valid_i;
            end else begin
                entry_d = new_entry_i;
                valid_d = 1'b1;
            end
        end else begin
            entry_d = entry_q;
            valid_d = valid_q;
        end
    end

    // Cell storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
        end
    end

    assign entry_o = entry_q;
    assign next_o  = entry_d;
    assign valid_o = valid_q;

endmodule

// File: rtl/count_rank_sorter.sv
// Captures per-image match counts on busy rising edges, keeps them sorted by
// descending count, and streams the ranked list on request.
module count_rank_sorter
    import count_rank_sorter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    count_rank_sorter_if.slave bus
);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic [PTR_W-1:0] entries_q, entries_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             done_q, done_d;
    logic             full_q, full_d;
    logic             dropped_q, dropped_d;

    logic             cap_s, room_s, ins_en_s, rd_go_s, rd_last_s;
    logic [PTR_W-1:0] entries_ins_s;
    rank_entry_t      new_entry_s;
    rank_entry_t      slot_entry_s [NUM_IMG];
    rank_entry_t      slot_next_s  [NUM_IMG];
    logic             slot_take_s  [NUM_IMG];
    logic             slot_valid_s [NUM_IMG];

    assign busy_d = bus.busy;

    // Event decode: capture edge, room in list, read launch and last-beat detection.
    always_comb begin
        cap_s         = bus.busy & ~busy_q;
        room_s        = (entries_q != PTR_W'(NUM_IMG));
        ins_en_s      = (state_q == COLLECT) & cap_s & room_s;
        entries_ins_s = entries_q + {{(PTR_W-1){1'b0}}, ins_en_s};
        rd_go_s       = (state_q == COLLECT) & bus.rd_start;
        rd_last_s     = (state_q == READ) & (rd_ptr_q == entries_q);
        new_entry_s   = '{id: entries_q[ID_W-1:0], count: bus.count};
    end

    for (genvar i = 0; i < NUM_IMG; i++) begin : g_slot
        logic        up_take_s;
        rank_entry_t up_entry_s;
        logic        up_valid_s;
        if (i == 0) begin : g_head
            assign up_take_s  = 1'b0;
            assign up_entry_s = '0;
            assign up_valid_s = 1'b0;
        end else begin : g_link
            assign up_take_s  = slot_take_s[i-1];
            assign up_entry_s = slot_entry_s[i-1];
            assign up_valid_s = slot_valid_s[i-1];
        end
        count_rank_sorter_rank_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (rd_last_s),
            .ins_en_i    (ins_en_s),
            .new_entry_i (new_entry_s),
            .up_take_i   (up_take_s),
            .up_entry_i  (up_entry_s),
            .up_valid_i  (up_valid_s),
            .take_o      (slot_take_s[i]),
            .entry_o     (slot_entry_s[i]),
            .next_o      (slot_next_s[i]),
            .valid_o     (slot_valid_s[i])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enter READ only when something (incl. a same-cycle capture) is held.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (rd_go_s && (entries_ins_s != {PTR_W{1'b0}})) begin
                    state_d = READ;
                end else begin
                    state_d = COLLECT;
                end
            end
            READ: begin
                if (rd_last_s) begin
                    state_d = COLLECT;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output/datapath logic. The first beat is loaded from slot 0's next value so a
    // capture arriving with rd_start is already ranked in it.
    always_comb begin
        entries_d   = entries_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_count_d = out_count_q;
        done_d      = 1'b0;
        dropped_d   = dropped_q;
        case (state_q)
            COLLECT: begin
                entries_d = entries_ins_s;
                if (cap_s && !room_s) begin
                    dropped_d = 1'b1;
                end else begin
                    dropped_d = dropped_q;
                end
                if (rd_go_s) begin
                    if (entries_ins_s != {PTR_W{1'b0}}) begin
                        out_valid_d = 1'b1;
                        out_id_d    = slot_next_s[0].id;
                        out_count_d = slot_next_s[0].count;
                        rd_ptr_d    = PTR_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    rd_ptr_d = {PTR_W{1'b0}};
                end
            end
            READ: begin
                if (cap_s) begin
                    dropped_d = 1'b1;
                end else begin
                    dropped_d = dropped_q;
                end
                if (rd_last_s) begin
                    done_d    = 1'b1;
                    entries_d = {PTR_W{1'b0}};
                    rd_ptr_d  = {PTR_W{1'b0}};
                end else begin
                    out_valid_d = 1'b1;
                    out_id_d    = slot_entry_s[rd_ptr_q[ID_W-1:0]].id;
                    out_count_d = slot_entry_s[rd_ptr_q[ID_W-1:0]].count;
                    rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                end
            end
            default: begin
                entries_d = entries_q;
            end
        endcase
        full_d = (entries_d == PTR_W'(NUM_IMG));
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            entries_q   <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            out_valid_q <= 1'b0;
            out_id_q    <= {ID_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            entries_q   <= entries_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_count_q <= out_count_d;
            done_q      <= done_d;
            full_q      <= full_d;
            dropped_q   <= dropped_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_count = out_count_q;
    assign bus.done      = done_q;
    assign bus.entries   = entries_q;
    assign bus.full      = full_q;
    assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_count_rank_sorter.sv
// Scoreboard bench for count_rank_sorter: expected beats are queued when a read
// is launched; a negedge monitor pops and compares every out_valid/done cycle.
module tb_count_rank_sorter;
    import count_rank_sorter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    count_rank_sorter_if bus_if ();

    count_rank_sorter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        bit               is_done;
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_beat(input int id, input int cnt);
        exp_t e;
        e.is_done = 1'b0;
        e.id      = ID_W'(id);
        e.cnt     = CNT_W'(cnt);
        sb.push_back(e);
    endtask

    task automatic exp_done();
        exp_t e;
        e.is_done = 1'b1;
        e.id      = '0;
        e.cnt     = '0;
        sb.push_back(e);
    endtask

    task automatic capture(input int val);
        bus_if.busy  = 1'b1;
        bus_if.count = CNT_W'(val);
        step(1);
        bus_if.busy  = 1'b0;
        step(1);
    endtask

    task automatic read_list(input int nwait);
        bus_if.rd_start = 1'b1;
        step(1);
        bus_if.rd_start = 1'b0;
        step(nwait);
    endtask

    // Monitor: every output beat or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus_if.out_valid === 1'b1 || bus_if.done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output valid=%0b done=%0b id=%0d count=%0d required=nothing",
                         bus_if.out_valid, bus_if.done, bus_if.out_id, bus_if.out_count);
            end else begin
                mon_e = sb.pop_front();
                if ((bus_if.done !== mon_e.is_done) || (bus_if.out_valid !== !mon_e.is_done) ||
                    (!mon_e.is_done && ((bus_if.out_id !== mon_e.id) || (bus_if.out_count !== mon_e.cnt)))) begin
                    failures++;
                    $display("FAIL stream actual valid=%0b done=%0b id=%0d count=%0d required done=%0b id=%0d count=%0d",
                             bus_if.out_valid, bus_if.done, bus_if.out_id, bus_if.out_count,
                             mon_e.is_done, mon_e.id, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus_if.busy     = 1'b0;
        bus_if.count    = '0;
        bus_if.rd_start = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", int'(bus_if.out_valid), 0);
        chk("rst_out_id",    int'(bus_if.out_id),    0);
        chk("rst_out_count", int'(bus_if.out_count), 0);
        chk("rst_done",      int'(bus_if.done),      0);
        chk("rst_entries",   int'(bus_if.entries),   0);
        chk("rst_full",      int'(bus_if.full),      0);
        chk("rst_dropped",   int'(bus_if.dropped),   0);

        // Basic: 5,20,20,0 -> (1,20),(2,20),(0,5),(3,0)
        capture(5);
        capture(20);
        capture(20);
        capture(0);
        chk("basic_entries", int'(bus_if.entries), 4);
        exp_beat(1, 20); exp_beat(2, 20); exp_beat(0, 5); exp_beat(3, 0); exp_done();
        read_list(8);
        chk("basic_drained", sb.size(), 0);
        chk("basic_entries_after", int'(bus_if.entries), 0);

        // Empty read: done only
        exp_done();
        read_list(3);
        chk("empty_drained", sb.size(), 0);
        chk("empty_entries", int'(bus_if.entries), 0);

        // Busy held high: one capture of the first sampled value
        bus_if.busy  = 1'b1;
        bus_if.count = CNT_W'(100);
        step(1);
        bus_if.count = CNT_W'(200);
        step(9);
        bus_if.busy = 1'b0;
        step(1);
        chk("hold_entries", int'(bus_if.entries), 1);
        capture(100);
        // Capture coinciding with rd_start is ranked before readout
        exp_beat(2, 32767); exp_beat(0, 100); exp_beat(1, 100); exp_done();
        bus_if.busy     = 1'b1;
        bus_if.count    = CNT_W'(32767);
        bus_if.rd_start = 1'b1;
        step(1);
        bus_if.busy     = 1'b0;
        bus_if.rd_start = 1'b0;
        step(7);
        chk("hold_drained", sb.size(), 0);
        chk("hold_entries_after", int'(bus_if.entries), 0);

        // Full / overflow
        capture(10); capture(30); capture(20); capture(30);
        capture(0);  capture(50); capture(10); capture(40);
        chk("full_entries", int'(bus_if.entries), 8);
        chk("full_flag",    int'(bus_if.full),    1);
        chk("full_dropped_before", int'(bus_if.dropped), 0);
        capture(99);
        chk("ovf_entries", int'(bus_if.entries), 8);
        chk("ovf_dropped", int'(bus_if.dropped), 1);
        exp_beat(5, 50); exp_beat(7, 40); exp_beat(1, 30); exp_beat(3, 30);
        exp_beat(2, 20); exp_beat(0, 10); exp_beat(6, 10); exp_beat(4, 0); exp_done();
        read_list(12);
        chk("ovf_drained", sb.size(), 0);
        chk("ovf_full_after", int'(bus_if.full), 0);
        chk("ovf_dropped_sticky", int'(bus_if.dropped), 1);

        // Reset pulse clears sticky dropped
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst2_dropped", int'(bus_if.dropped), 0);

        // Capture during READ is discarded
        capture(7);
        capture(9);
        exp_beat(1, 9); exp_beat(0, 7); exp_done();
        bus_if.rd_start = 1'b1;
        step(1);
        bus_if.rd_start = 1'b0;
        bus_if.busy     = 1'b1;
        bus_if.count    = CNT_W'(55);
        step(1);
        bus_if.busy = 1'b0;
        step(4);
        chk("rdcap_dropped", int'(bus_if.dropped), 1);
        chk("rdcap_drained", sb.size(), 0);
        chk("rdcap_entries", int'(bus_if.entries), 0);

        // Next batch restarts ids at 0
        capture(3);
        chk("batch2_entries", int'(bus_if.entries), 1);
        exp_beat(0, 3); exp_done();
        read_list(4);
        chk("batch2_drained", sb.size(), 0);

        // Reset on the 2nd read beat: no further beats, no done
        capture(1); capture(2); capture(3);
        exp_beat(2, 3); exp_beat(1, 2);
        bus_if.rd_start = 1'b1;
        step(1);
        bus_if.rd_start = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rstrd_out_valid", int'(bus_if.out_valid), 0);
        chk("rstrd_done",      int'(bus_if.done),      0);
        chk("rstrd_entries",   int'(bus_if.entries),   0);
        chk("rstrd_dropped",   int'(bus_if.dropped),   0);
        step(5);
        chk("rstrd_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
